// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit active-low 7-segment
// display. Holds an 8-entry digit buffer written through two requester
// ports (A has fixed priority over B) and scans the digits one slot at a
// time. Each slot starts with a one-cycle blanking guard on AN.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter bit HEX      = 1'b1
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       en,
    input  logic       a_req,
    input  logic [2:0] a_addr,
    input  logic [4:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [2:0] b_addr,
    input  logic [4:0] b_data,
    output logic       b_ack,
    output logic [7:0] SEG,
    output logic [7:0] AN,
    output logic [2:0] cur_digit
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
    localparam logic [4:0]    ENTRY_BLANK = 5'b1_0000;
    localparam logic [7:0]    ALL_OFF     = 8'hFF;

    // Entry to active-low segment pattern; dp (bit 7) is always off.
    function automatic logic [7:0] seg_decode(input logic [4:0] entry);
        logic [7:0] pat;
        pat = ALL_OFF;
        if (entry[4]) begin
            pat = ALL_OFF;
        end else begin
            case (entry[3:0])
                4'h0:    pat = 8'hC0;
                4'h1:    pat = 8'hF9;
                4'h2:    pat = 8'hA4;
                4'h3:    pat = 8'hB0;
                4'h4:    pat = 8'h99;
                4'h5:    pat = 8'h92;
                4'h6:    pat = 8'h82;
                4'h7:    pat = 8'hF8;
                4'h8:    pat = 8'h80;
                4'h9:    pat = 8'h90;
                4'hA:    pat = HEX ? 8'h88 : ALL_OFF;
                4'hB:    pat = HEX ? 8'h83 : ALL_OFF;
                4'hC:    pat = HEX ? 8'hC6 : ALL_OFF;
                4'hD:    pat = HEX ? 8'hA1 : ALL_OFF;
                4'hE:    pat = HEX ? 8'h86 : ALL_OFF;
                4'hF:    pat = HEX ? 8'h8E : ALL_OFF;
                default: pat = ALL_OFF;
            endcase
        end
        return pat;
    endfunction

    logic [4:0]    digit_buf_r [8];
    logic [PW-1:0] pcnt_r;
    logic [2:0]    cur_digit_r;
    logic [7:0]    seg_r;
    logic [7:0]    an_r;
    logic          a_ack_r;
    logic          b_ack_r;

    logic          wr_en_s;
    logic [2:0]    wr_addr_s;
    logic [4:0]    wr_data_s;
    logic          a_win_s;
    logic          b_win_s;
    logic          wrap_s;
    logic [PW-1:0] pcnt_nxt_s;
    logic [2:0]    digit_nxt_s;
    logic [7:0]    seg_nxt_s;
    logic [7:0]    an_nxt_s;

    // Fixed-priority write arbitration: port A wins whenever it requests.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 3'd0;
        wr_data_s = 5'd0;
        a_win_s   = 1'b0;
        b_win_s   = 1'b0;
        if (a_req) begin
            wr_en_s   = 1'b1;
            wr_addr_s = a_addr;
            wr_data_s = a_data;
            a_win_s   = 1'b1;
        end else if (b_req) begin
            wr_en_s   = 1'b1;
            wr_addr_s = b_addr;
            wr_data_s = b_data;
            b_win_s   = 1'b1;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Terminal count of the prescaler ends the current digit slot.
    assign wrap_s = en && (pcnt_r == PCNT_LAST);

    // Prescaler and digit index advance; both freeze while scanning is off.
    always_comb begin
        pcnt_nxt_s  = pcnt_r;
        digit_nxt_s = cur_digit_r;
        if (en) begin
            if (wrap_s) begin
                pcnt_nxt_s  = '0;
                digit_nxt_s = cur_digit_r + 3'd1;
            end else begin
                pcnt_nxt_s  = pcnt_r + PCNT_ONE;
                digit_nxt_s = cur_digit_r;
            end
        end else begin
            pcnt_nxt_s  = pcnt_r;
            digit_nxt_s = cur_digit_r;
        end
    end

    // Display drive; blanked when disabled and in the guard cycle that
    // follows a digit advance (the advance edge registers all-off).
    always_comb begin
        seg_nxt_s = ALL_OFF;
        an_nxt_s  = ALL_OFF;
        if (!en || wrap_s) begin
            seg_nxt_s = ALL_OFF;
            an_nxt_s  = ALL_OFF;
        end else begin
            seg_nxt_s = seg_decode(digit_buf_r[cur_digit_r]);
            an_nxt_s  = ~(8'b0000_0001 << cur_digit_r);
        end
    end

    // Digit buffer storage; every entry resets to blank.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 8; i++) begin
                digit_buf_r[i] <= ENTRY_BLANK;
            end
        end else if (wr_en_s) begin
            digit_buf_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Scan position state.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pcnt_r      <= '0;
            cur_digit_r <= 3'd0;
        end else begin
            pcnt_r      <= pcnt_nxt_s;
            cur_digit_r <= digit_nxt_s;
        end
    end

    // Registered display pins and write acknowledges.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            seg_r   <= ALL_OFF;
            an_r    <= ALL_OFF;
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
        end else begin
            seg_r   <= seg_nxt_s;
            an_r    <= an_nxt_s;
            a_ack_r <= a_win_s;
            b_ack_r <= b_win_s;
        end
    end

    assign SEG       = seg_r;
    assign AN        = an_r;
    assign a_ack     = a_ack_r;
    assign b_ack     = b_ack_r;
    assign cur_digit = cur_digit_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for seg_scan_ctrl. Two instances share stimulus:
// one decoding hex letters, one blanking them. Expected values come from
// a time-based reference model: the count of enabled edges determines
// the digit and slot position directly.
module tb_seg_scan_ctrl;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       a_req = 1'b0, b_req = 1'b0;
    logic [2:0] a_addr = 3'd0, b_addr = 3'd0;
    logic [4:0] a_data = 5'd0, b_data = 5'd0;
    logic       a_ack1, b_ack1, a_ack0, b_ack0;
    logic [7:0] seg1, an1, seg0, an0;
    logic [2:0] cd1, cd0;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int         t;
    logic [4:0] mbuf [8];
    logic [7:0] exp_seg1, exp_seg0, exp_an;
    logic       exp_aack, exp_back;
    logic [2:0] exp_cd;

    logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_ctrl #(.SCAN_DIV(SD), .HEX(1'b1)) u_dut_hex (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack1),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack1),
        .SEG(seg1), .AN(an1), .cur_digit(cd1)
    );

    seg_scan_ctrl #(.SCAN_DIV(SD), .HEX(1'b0)) u_dut_dec (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack0),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack0),
        .SEG(seg0), .AN(an0), .cur_digit(cd0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_dec(input logic [4:0] e, input bit hex);
        if (e[4]) return 8'hFF;
        if (e[3:0] > 4'd9 && !hex) return 8'hFF;
        return dec_tab[e[3:0]];
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 8; i++) mbuf[i] = 5'b1_0000;
        exp_seg1 = 8'hFF; exp_seg0 = 8'hFF; exp_an = 8'hFF;
        exp_aack = 1'b0;  exp_back = 1'b0;  exp_cd = 3'd0;
    endtask

    // Advance the model by one clock edge using the current inputs,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        int pos, dig;
        exp_aack = a_req;
        exp_back = !a_req && b_req;
        if (en) begin
            pos = t % SD;
            dig = (t / SD) % 8;
            if (pos == SD - 1) begin
                exp_seg1 = 8'hFF; exp_seg0 = 8'hFF; exp_an = 8'hFF;
            end else begin
                exp_seg1 = ref_dec(mbuf[dig], 1'b1);
                exp_seg0 = ref_dec(mbuf[dig], 1'b0);
                exp_an   = ~(8'h01 << dig);
            end
            t++;
        end else begin
            exp_seg1 = 8'hFF; exp_seg0 = 8'hFF; exp_an = 8'hFF;
        end
        if (a_req) mbuf[a_addr] = a_data;
        else if (b_req) mbuf[b_addr] = b_data;
        exp_cd = 3'((t / SD) % 8);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({seg1, an1, seg0, an0} !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_outputs: seg1=%h an1=%h seg0=%h an0=%h required all FF", seg1, an1, seg0, an0);
        end
        n_cmp++;
        if ({cd1, a_ack1, b_ack1} !== 5'b000_0_0) begin
            n_err++;
            $display("FAIL reset_state: cur_digit=%0d a_ack=%b b_ack=%b required 0/0/0", cd1, a_ack1, b_ack1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        int guards = 0;
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i < 32 && an1 === 8'hFF) guards++;
            n_cmp++;
            if (an1 !== exp_an || seg1 !== 8'hFF || cd1 !== exp_cd) begin
                n_err++;
                $display("FAIL idle_scan[%0d]: an=%h seg=%h cd=%0d required an=%h seg=FF cd=%0d",
                         i, an1, seg1, cd1, exp_an, exp_cd);
            end
        end
        n_cmp++;
        if (guards != 8) begin
            n_err++;
            $display("FAIL idle_guard_count: got %0d guard cycles in one frame, required 8", guards);
        end
    endtask

    task automatic test_write_display();
        bit found = 1'b0;
        a_req = 1'b1; a_addr = 3'd3; a_data = 5'h07;
        tick();
        n_cmp++;
        if (a_ack1 !== 1'b1) begin
            n_err++;
            $display("FAIL write_ack: a_ack=%b required 1", a_ack1);
        end
        a_req = 1'b0;
        tick();
        n_cmp++;
        if (a_ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL write_ack_drop: a_ack=%b required 0", a_ack1);
        end
        for (int i = 0; i < 8 * SD + 4 && !found; i++) begin
            tick();
            if (an1 === 8'hF7) found = 1'b1;
        end
        n_cmp++;
        if (!found || seg1 !== 8'hF8 || seg0 !== 8'hF8) begin
            n_err++;
            $display("FAIL write_display: found=%b seg1=%h seg0=%h required AN=F7 SEG=F8", found, seg1, seg0);
        end
    endtask

    task automatic test_priority();
        bit found = 1'b0;
        a_req = 1'b1; a_addr = 3'd0; a_data = 5'h01;
        b_req = 1'b1; b_addr = 3'd0; b_data = 5'h02;
        tick();
        n_cmp++;
        if (a_ack1 !== 1'b1 || b_ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL prio_cycle1: a_ack=%b b_ack=%b required 1/0", a_ack1, b_ack1);
        end
        a_req = 1'b0;
        tick();
        n_cmp++;
        if (a_ack1 !== 1'b0 || b_ack1 !== 1'b1) begin
            n_err++;
            $display("FAIL prio_cycle2: a_ack=%b b_ack=%b required 0/1", a_ack1, b_ack1);
        end
        b_req = 1'b0;
        tick();
        n_cmp++;
        if (b_ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL prio_cycle3: b_ack=%b required 0", b_ack1);
        end
        for (int i = 0; i < 8 * SD + 4 && !found; i++) begin
            tick();
            if (an1 === 8'hFE) found = 1'b1;
        end
        n_cmp++;
        if (!found || seg1 !== 8'hA4) begin
            n_err++;
            $display("FAIL prio_final: found=%b seg=%h required AN=FE SEG=A4", found, seg1);
        end
    endtask

    task automatic test_hex();
        bit found = 1'b0;
        b_req = 1'b1; b_addr = 3'd5; b_data = 5'h0C;
        tick();
        n_cmp++;
        if (b_ack1 !== 1'b1) begin
            n_err++;
            $display("FAIL hex_b_ack: b_ack=%b required 1", b_ack1);
        end
        b_req = 1'b0;
        for (int i = 0; i < 8 * SD + 4 && !found; i++) begin
            tick();
            if (an1 === 8'hDF) found = 1'b1;
        end
        n_cmp++;
        if (!found || seg1 !== 8'hC6 || seg0 !== 8'hFF) begin
            n_err++;
            $display("FAIL hex_decode: found=%b hex1=%h hex0=%h required C6/FF", found, seg1, seg0);
        end
    endtask

    task automatic test_en_pause();
        logic [2:0] cd_saved;
        logic [7:0] an_req;
        for (int i = 0; i < 2 * SD && (t % SD) != 1; i++) tick();
        cd_saved = cd1;
        an_req = ~(8'h01 << cd_saved);
        en = 1'b0;
        tick();
        n_cmp++;
        if (an1 !== 8'hFF || seg1 !== 8'hFF || cd1 !== cd_saved) begin
            n_err++;
            $display("FAIL pause_blank: an=%h seg=%h cd=%0d required FF/FF/%0d", an1, seg1, cd1, cd_saved);
        end
        a_req = 1'b1; a_addr = 3'd2; a_data = 5'h15;
        tick();
        n_cmp++;
        if (a_ack1 !== 1'b1) begin
            n_err++;
            $display("FAIL pause_write_ack: a_ack=%b required 1", a_ack1);
        end
        a_req = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (cd1 !== cd_saved || an1 !== 8'hFF) begin
            n_err++;
            $display("FAIL pause_frozen: cd=%0d an=%h required %0d/FF", cd1, an1, cd_saved);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (an1 !== an_req || an1 !== exp_an) begin
            n_err++;
            $display("FAIL resume_digit: an=%h required %h", an1, an_req);
        end
        tick();
        n_cmp++;
        if (an1 !== an_req) begin
            n_err++;
            $display("FAIL resume_remaining: an=%h required %h", an1, an_req);
        end
        tick();
        n_cmp++;
        if (an1 !== 8'hFF || cd1 !== cd_saved + 3'd1) begin
            n_err++;
            $display("FAIL resume_guard: an=%h cd=%0d required FF/%0d", an1, cd1, cd_saved + 3'd1);
        end
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 2 * SD && an1 === 8'hFF; i++) tick();
        a_req = 1'b1; a_addr = 3'd0; a_data = 5'h08;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (seg1 !== 8'hFF || an1 !== 8'hFF || cd1 !== 3'd0 || a_ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: seg=%h an=%h cd=%0d a_ack=%b required FF/FF/0/0", seg1, an1, cd1, a_ack1);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        n_cmp++;
        if (a_ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_ack: a_ack=%b required 0", a_ack1);
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 8 * SD; i++) begin
            tick();
            n_cmp++;
            if (seg1 !== 8'hFF || an1 !== exp_an) begin
                n_err++;
                $display("FAIL post_reset_blank[%0d]: seg=%h an=%h required FF/%h", i, seg1, an1, exp_an);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            a_req  = ($urandom_range(0, 3) == 0);
            b_req  = ($urandom_range(0, 2) == 0);
            a_addr = 3'($urandom_range(0, 7));
            b_addr = 3'($urandom_range(0, 7));
            a_data = 5'($urandom_range(0, 31));
            b_data = 5'($urandom_range(0, 31));
            tick();
            n_cmp++;
            if (seg1 !== exp_seg1 || seg0 !== exp_seg0) begin
                n_err++;
                $display("FAIL rand_seg[%0d]: hex1=%h hex0=%h required %h/%h", i, seg1, seg0, exp_seg1, exp_seg0);
            end
            n_cmp++;
            if (an1 !== exp_an || an0 !== exp_an || cd1 !== exp_cd || cd0 !== exp_cd) begin
                n_err++;
                $display("FAIL rand_scan[%0d]: an=%h/%h cd=%0d/%0d required %h cd=%0d",
                         i, an1, an0, cd1, cd0, exp_an, exp_cd);
            end
            n_cmp++;
            if (a_ack1 !== exp_aack || b_ack1 !== exp_back || a_ack0 !== exp_aack || b_ack0 !== exp_back) begin
                n_err++;
                $display("FAIL rand_ack[%0d]: a=%b/%b b=%b/%b required a=%b b=%b",
                         i, a_ack1, a_ack0, b_ack1, b_ack0, exp_aack, exp_back);
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_write_display();
        test_priority();
        test_hex();
        test_en_pause();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
